// File: rtl/rvfpm_issue_ctrl.sv
// Issue and scoreboard controller in front of the rvfpm pipeline.
// Decodes RV32F instructions, stalls on RAW/WAW hazards against in-flight
// destinations, tracks the fixed-latency pipeline in a slot shift register
// and freezes everything while an X-register result waits for the core.
module rvfpm_issue_ctrl #(
    parameter int NUM_REGS        = 32,
    parameter int PIPELINE_STAGES = 3,
    parameter int ID_W            = 4
) (
    input  logic                ck,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instruction,
    input  logic [ID_W-1:0]     instr_id,
    input  logic                flush,
    output logic                pipe_adv,
    output logic                pipe_issue,
    output logic [31:0]         pipe_instr,
    output logic                wb_fp_valid,
    output logic [4:0]          wb_fp_rd,
    output logic                xres_valid,
    input  logic                xres_ready,
    output logic [ID_W-1:0]     xres_id,
    output logic [NUM_REGS-1:0] busy,
    output logic                illegal
);

    localparam int LAST = PIPELINE_STAGES - 1;

    typedef struct packed {
        logic            v;
        logic [4:0]      rd;
        logic            wfp;
        logic            wx;
        logic [ID_W-1:0] id;
    } slot_t;

    slot_t               slot_q [PIPELINE_STAGES];
    slot_t               slot_d [PIPELINE_STAGES];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic       legal;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rs3;
    logic       wfp;
    logic       wx;
    logic       hazard;
    logic       accept;
    slot_t      last;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign rs3    = instruction[31:27];
    assign funct7 = instruction[31:25];
    assign last   = slot_q[LAST];

    // Decode which FP registers the instruction reads and what it writes.
    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rs3 = 1'b0;
        wfp     = 1'b0;
        wx      = 1'b0;
        case (opcode)
            7'b0000111: begin
                legal = 1'b1;
                wfp   = 1'b1;
            end
            7'b0100111: begin
                legal   = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                legal   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rs3 = 1'b1;
                wfp     = 1'b1;
            end
            7'b1010011: begin
                legal = 1'b1;
                case (funct7)
                    7'b1110000, 7'b1100000: begin
                        use_rs1 = 1'b1;
                        wx      = 1'b1;
                    end
                    7'b1010000: begin
                        use_rs1 = 1'b1;
                        use_rs2 = 1'b1;
                        wx      = 1'b1;
                    end
                    7'b1101000, 7'b1111000: begin
                        wfp = 1'b1;
                    end
                    7'b0101100: begin
                        use_rs1 = 1'b1;
                        wfp     = 1'b1;
                    end
                    default: begin
                        use_rs1 = 1'b1;
                        use_rs2 = 1'b1;
                        wfp     = 1'b1;
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Hazard check against the registered scoreboard only; a register that
    // retires this cycle still blocks its consumer for one more cycle.
    always_comb begin
        hazard = (use_rs1 && busy_q[rs1]) ||
                 (use_rs2 && busy_q[rs2]) ||
                 (use_rs3 && busy_q[rs3]) ||
                 (wfp     && busy_q[rd]);
    end

    // Handshake, freeze and retire outputs.
    always_comb begin
        pipe_adv    = rst && !(last.v && last.wx && !xres_ready);
        instr_ready = rst && !flush && pipe_adv && !hazard;
        accept      = instr_valid && instr_ready;
        pipe_issue  = accept && legal;
        illegal     = accept && !legal;
        pipe_instr  = rst ? instruction : 32'h0;
        wb_fp_valid = last.v && last.wfp && pipe_adv && !flush;
        wb_fp_rd    = last.rd;
        xres_valid  = rst && last.v && last.wx && !flush;
        xres_id     = last.id;
        busy        = busy_q;
    end

    // Next slot contents: shift on advance, wipe on flush.
    always_comb begin
        for (int i = 0; i < PIPELINE_STAGES; i++) slot_d[i] = slot_q[i];
        if (flush) begin
            for (int i = 0; i < PIPELINE_STAGES; i++) slot_d[i] = '0;
        end else if (pipe_adv) begin
            for (int i = 1; i < PIPELINE_STAGES; i++) slot_d[i] = slot_q[i-1];
            slot_d[0] = '0;
            if (pipe_issue) begin
                slot_d[0].v   = 1'b1;
                slot_d[0].rd  = rd;
                slot_d[0].wfp = wfp;
                slot_d[0].wx  = wx;
                slot_d[0].id  = instr_id;
            end
        end
    end

    // Scoreboard next state; a set in the same cycle as a clear wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_fp_valid) busy_d[last.rd] = 1'b0;
        if (pipe_issue && wfp) busy_d[rd] = 1'b1;
        if (flush) busy_d = '0;
    end

    // Slot and scoreboard registers.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPELINE_STAGES; i++) slot_q[i] <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < PIPELINE_STAGES; i++) slot_q[i] <= slot_d[i];
            busy_q <= busy_d;
        end
    end

endmodule
